out_port_logger: RTL and testbench

- Downstream consumer of the CPU top level's 16-bit `out` bus.
- Detects every change of the bus value and tags it with a free-running cycle timestamp.
- Buffers the tagged records in a small FIFO and hands them to a debug sink (UART bridge or bench monitor) over a valid/ready interface.
- Lets the team trace program output at full speed without stalling the core.

---
 rtl/out_logger_pkg.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/out_port_logger.sv | 98 +++++++++
 tb/tb_out_port_logger.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/out_logger_pkg.sv
// Shared defaults, record layout and a constant-width helper for the
// out_port_logger slice.
package out_logger_pkg;

  // Default widths/depth of the logger.
  localparam int DATA_W_DEF = 16;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // Record layout for the default widths: {timestamp, value}.
  localparam int REC_W_DEF      = TS_W_DEF + DATA_W_DEF;
  localparam int REC_VAL_LSB    = 0;
  localparam int REC_VAL_MSB    = DATA_W_DEF - 1;
  localparam int REC_TS_LSB     = DATA_W_DEF;
  localparam int REC_TS_MSB     = TS_W_DEF + DATA_W_DEF - 1;

  // Ceiling log2, for sizing pointers and the occupancy counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// rdata whenever rvalid is high; a pop advances to the next entry. A push
// into a full FIFO is only accepted when a pop happens on the same edge.
module sync_fifo_fwft
  import out_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the occupancy count, so pointers can wrap freely.
  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while cnt is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Head presentation; zero when empty so nothing stale leaks out.
  always_comb begin
    rvalid = !empty;
    rdata  = empty ? '0 : mem[rd_ptr];
    level  = cnt;
  end

endmodule

// File: rtl/out_port_logger.sv
// Watches the CPU out bus, records every change with a free-running cycle
// timestamp and hands the records to a debug sink. The core is never
// stalled: when the buffer is full, new records are dropped and counted.
//
// Handshake: rec_valid/rec_data describe the oldest buffered record. A
// record is transferred on a rising edge where rec_valid and rec_ready are
// both high. While rec_valid is high and rec_ready low, rec_data holds and
// rec_valid stays high; rec_valid never depends on rec_ready.
module out_port_logger
  import out_logger_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        cpu_out,
  input  logic                     en,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TS_W+DATA_W-1:0]   rec_data,
  output logic [clog2(DEPTH):0]    level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     ovf_clr
);

  logic [TS_W-1:0]        ts;
  logic [DATA_W-1:0]      last;
  logic                   armed;
  logic                   capture;
  logic                   pop;
  logic                   full;
  logic                   drop;
  logic [TS_W+DATA_W-1:0] rec_in;

  // Capture on the first enabled edge after reset, then only on changes.
  // A full FIFO with no pop on the same edge turns the capture into a drop.
  always_comb begin
    capture = en && (armed || (cpu_out != last));
    pop     = rec_valid && rec_ready;
    drop    = capture && full && !pop;
    rec_in  = {ts, cpu_out};
  end

  // Free-running timestamp; wraps naturally and ignores en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  // Change detector state; last follows captures even when they are dropped
  // so a held value cannot retrigger later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= '0;
      armed <= 1'b1;
    end else if (capture) begin
      last  <= cpu_out;
      armed <= 1'b0;
    end
  end

  // Sticky overflow and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != {DROP_W{1'b1}})
        drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W + DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (capture),
    .wdata  (rec_in),
    .pop    (pop),
    .rdata  (rec_data),
    .rvalid (rec_valid),
    .level  (level),
    .full   (full)
  );

endmodule

// File: tb/tb_out_port_logger.sv
// Directed bench for out_port_logger: stimulus steps run linearly, expected
// records are kept in a queue and every comparison is an immediate assertion.
module tb_out_port_logger;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_out;
  logic        en;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_data;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;

  int total = 0;
  int bad   = 0;

  logic [15:0] cyc;
  logic [31:0] exp_q[$];

  out_port_logger #(
    .DATA_W (16),
    .TS_W   (16),
    .DEPTH  (8),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_out   (cpu_out),
    .en        (en),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  // Clock and cycle reference for expected timestamps.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 16'd0;
    else     cyc <= cyc + 16'd1;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a bus value for the next edge; record what the DUT should log.
  task automatic drive(input logic [15:0] v, input bit expect_push);
    cpu_out = v;
    if (expect_push) exp_q.push_back({cyc, v});
    step();
  endtask

  // Accept n records, comparing each against the scoreboard.
  task automatic drain(input int n);
    logic [31:0] e;
    rec_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", 32'(rec_valid), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("drain_data", rec_data, e);
      step();
    end
    rec_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    rst = 1'b1; en = 1'b0; rec_ready = 1'b0; ovf_clr = 1'b0; cpu_out = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", rec_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Armed capture: one edge with en low, then the first enabled edge (ts=1).
    rst = 1'b0;
    step();
    en = 1'b1;
    drive(16'h0000, 1'b1);
    chk("arm_level", 32'(level), 32'd1);
    chk("arm_rec", rec_data, 32'h0001_0000);
    drain(1);
    repeat (3) step();
    chk("arm_quiet_lvl", 32'(level), 32'd0);
    chk("arm_quiet_vld", 32'(rec_valid), 32'd0);

    // Change detection: repeated value is not logged.
    drive(16'h0005, 1'b1);
    drive(16'h0006, 1'b1);
    drive(16'h0006, 1'b0);
    drive(16'h0007, 1'b1);
    chk("chg_level", 32'(level), 32'd3);
    drain(3);
    chk("chg_empty", 32'(level), 32'd0);

    // en low: nothing captured, detector holds.
    en = 1'b0;
    drive(16'h0055, 1'b0);
    drive(16'h0066, 1'b0);
    chk("en_hold", 32'(level), 32'd0);
    en = 1'b1;
    drive(16'h0066, 1'b1);
    chk("en_resume", 32'(level), 32'd1);
    drain(1);

    // Overflow: 10 values into 8 entries.
    for (int i = 0; i < 10; i++) drive(16'(16'h0100 + i), i < 8);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    drain(8);
    chk("ovf_empty", 32'(level), 32'd0);

    // Full with a simultaneous pop: push accepted.
    for (int i = 0; i < 8; i++) drive(16'(16'h0200 + i), 1'b1);
    chk("fp_full", 32'(level), 32'd8);
    e = exp_q.pop_front();
    chk("fp_head", rec_data, e);
    rec_ready = 1'b1;
    drive(16'h0208, 1'b1);
    rec_ready = 1'b0;
    chk("fp_level", 32'(level), 32'd8);
    chk("fp_drops", 32'(drop_cnt), 32'd2);
    drain(8);
    chk("fp_empty", 32'(level), 32'd0);

    // Saturation and clear.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) drive(16'(16'h0300 + i), 1'b1);
    for (int i = 0; i < 255; i++) drive(16'(16'h3000 + i), 1'b0);
    chk("sat_255", 32'(drop_cnt), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    drive(16'h3100, 1'b0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr2_ovf", 32'(overflow), 32'd0);
    chk("clr2_drop", 32'(drop_cnt), 32'd0);
    ovf_clr = 1'b1;
    drive(16'h3200, 1'b0);
    ovf_clr = 1'b0;
    chk("clrdrop_ovf", 32'(overflow), 32'd1);
    chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
    chk("clrdrop_lvl", 32'(level), 32'd8);
    drain(8);

    // Reset mid-operation with 5 records buffered.
    for (int i = 0; i < 5; i++) drive(16'(16'h0400 + i), 1'b1);
    chk("mid_level", 32'(level), 32'd5);
    chk("mid_valid", 32'(rec_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rec_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_data", rec_data, 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    drive(16'h0404, 1'b1);
    chk("rst_armed", rec_data, 32'h0000_0404);
    drain(1);
    repeat (2) step();
    chk("end_level", 32'(level), 32'd0);
    chk("end_valid", 32'(rec_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
